// File: rtl/rijndael_pkg.sv
// Shared Rijndael definitions: round count, controller FSM encoding,
// ShiftRows offsets and the GF(2^8) byte arithmetic used by the round datapath.
package rijndael_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } fsm_e;

  function automatic int nr(input int nb, input int nk);
    return ((nb > nk) ? nb : nk) + 6;
  endfunction

  // Row r is rotated left by this many columns; only 256-bit blocks differ.
  function automatic int shift_ofs(input int nb, input int row);
    case (row)
      0:       return 0;
      1:       return 1;
      2:       return (nb == 8) ? 3 : 2;
      3:       return (nb == 8) ? 4 : 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      else      p = p;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as b^254 (maps 0 to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/rijndael_mixcolumns.sv
// MixColumns over all NB columns of a column-major state (byte 0 in the MSBs).
module rijndael_mixcolumns
  import rijndael_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] state_i,
  output logic [32*NB-1:0] state_o
);

  localparam int SS = 32 * NB;

  // Each column is mixed independently.
  always_comb begin
    state_o = '0;
    for (int c = 0; c < NB; c++) begin
      state_o[SS-1-32*c -: 32] = mix_col(state_i[SS-1-32*c -: 32]);
    end
  end

endmodule

// File: rtl/rijndael_round.sv
// One combinational Rijndael round; final_i drops MixColumns for the last round.
module rijndael_round
  import rijndael_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] state_i,
  input  logic [32*NB-1:0] rkey_i,
  input  logic             final_i,
  output logic [32*NB-1:0] state_o
);

  localparam int SS = 32 * NB;

  logic [SS-1:0] sub;
  logic [SS-1:0] shifted;
  logic [SS-1:0] mixed;

  // SubBytes then ShiftRows; byte (row r, column c) sits at index 4*c + r.
  always_comb begin
    sub     = '0;
    shifted = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub[SS-1-8*(4*c+r) -: 8] = sbox(state_i[SS-1-8*(4*c+r) -: 8]);
      end
    end
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[SS-1-8*(4*c+r) -: 8] = sub[SS-1-8*(4*((c + shift_ofs(NB, r)) % NB)+r) -: 8];
      end
    end
  end

  rijndael_mixcolumns #(.NB(NB)) u_mixcolumns (
    .state_i (shifted),
    .state_o (mixed)
  );

  assign state_o = (final_i ? shifted : mixed) ^ rkey_i;

endmodule

// File: rtl/rijndael_round_ctrl.sv
// Iterative Rijndael encryption controller: sequences one round per fetched
// round key through rijndael_round and hands the ciphertext downstream.
module rijndael_round_ctrl
  import rijndael_pkg::*;
#(
  parameter  int NB        = 4,
  parameter  int NK        = 4,
  localparam int STATESIZE = 32 * NB,
  localparam int NR        = nr(NB, NK)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [STATESIZE-1:0] state_i,
  output logic                 rkey_req_o,
  output logic [3:0]           rkey_idx_o,
  input  logic                 rkey_valid_i,
  input  logic [STATESIZE-1:0] rkey_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [STATESIZE-1:0] state_o,
  output logic                 busy_o
);

  localparam logic [3:0] NR4 = 4'(NR);

  fsm_e                 fsm;
  fsm_e                 fsm_next;
  logic [STATESIZE-1:0] blk;
  logic [STATESIZE-1:0] round_out;
  logic [3:0]           rnd;

  rijndael_round #(.NB(NB)) u_round (
    .state_i (blk),
    .rkey_i  (rkey_i),
    .final_i (fsm == ST_FINAL),
    .state_o (round_out)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fsm <= ST_IDLE;
    else         fsm <= fsm_next;
  end

  // Next-state logic; rkey_valid_i only matters in the key-requesting states.
  always_comb begin
    fsm_next = fsm;
    case (fsm)
      ST_IDLE: begin
        if (in_valid_i) fsm_next = ST_INIT;
        else            fsm_next = ST_IDLE;
      end
      ST_INIT: begin
        if (rkey_valid_i) fsm_next = (NR4 == 4'd1) ? ST_FINAL : ST_ROUND;
        else              fsm_next = ST_INIT;
      end
      ST_ROUND: begin
        if (rkey_valid_i) fsm_next = ((rnd + 4'd1) == NR4) ? ST_FINAL : ST_ROUND;
        else              fsm_next = ST_ROUND;
      end
      ST_FINAL: begin
        if (rkey_valid_i) fsm_next = ST_DONE;
        else              fsm_next = ST_FINAL;
      end
      ST_DONE: begin
        if (out_ready_i) fsm_next = ST_IDLE;
        else             fsm_next = ST_DONE;
      end
      default: fsm_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded purely from the state register.
  always_comb begin
    in_ready_o  = 1'b0;
    busy_o      = 1'b1;
    rkey_req_o  = 1'b0;
    out_valid_o = 1'b0;
    case (fsm)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
      end
      ST_INIT, ST_ROUND, ST_FINAL: rkey_req_o  = 1'b1;
      ST_DONE:                     out_valid_o = 1'b1;
      default:                     busy_o      = 1'b1;
    endcase
  end

  // State register and round counter; the counter doubles as the key index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blk <= '0;
      rnd <= 4'd0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (in_valid_i) begin
            blk <= state_i;
            rnd <= 4'd0;
          end
        end
        ST_INIT: begin
          if (rkey_valid_i) begin
            blk <= blk ^ rkey_i;
            rnd <= 4'd1;
          end
        end
        ST_ROUND, ST_FINAL: begin
          if (rkey_valid_i) begin
            blk <= round_out;
            rnd <= rnd + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready_i) rnd <= 4'd0;
        end
        default: rnd <= 4'd0;
      endcase
    end
  end

  assign rkey_idx_o = rnd;
  assign state_o    = blk;

endmodule

// File: tb/tb_rijndael_round_ctrl.sv
// Scoreboard bench for rijndael_round_ctrl: three instances (AES-128/192/256)
// fed by a table-driven key schedule and a key source with optional latency.
module tb_rijndael_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] state_in  [3];
  logic         rkey_req  [3];
  logic [3:0]   rkey_idx  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] state_out [3];
  logic         busy      [3];
  logic [127:0] rk        [3][15];
  logic [127:0] exp_q     [3][$];
  bit           rand_lat  [3];
  bit           spur      [3];
  int           checks;
  int           errors;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PTB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic [127:0] sbox_rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    logic         rkey_valid;
    logic [127:0] rkey;

    rijndael_round_ctrl #(.NB(4), .NK(4 + 2*g)) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .in_valid_i   (in_valid[g]),
      .in_ready_o   (in_ready[g]),
      .state_i      (state_in[g]),
      .rkey_req_o   (rkey_req[g]),
      .rkey_idx_o   (rkey_idx[g]),
      .rkey_valid_i (rkey_valid),
      .rkey_i       (rkey),
      .out_valid_o  (out_valid[g]),
      .out_ready_i  (out_ready[g]),
      .state_o      (state_out[g]),
      .busy_o       (busy[g])
    );

    // Key source: answers each request after 0 (or random 0..5) cycles.
    initial begin : key_src
      bit         pending;
      bit         prev_wait;
      int         lat;
      logic [3:0] prev_idx;
      pending = 1'b0; prev_wait = 1'b0; lat = 0; prev_idx = 4'd0;
      rkey_valid = 1'b0; rkey = '0;
      forever begin
        @(negedge clk);
        if (prev_wait && rst_n) begin
          check($sformatf("idx_hold%0d", g), {124'd0, rkey_idx[g]}, {124'd0, prev_idx});
          check($sformatf("req_hold%0d", g), {127'd0, rkey_req[g]}, 128'd1);
        end
        if (rkey_valid) pending = 1'b0;
        if (!rst_n || !rkey_req[g]) begin
          pending    = 1'b0;
          prev_wait  = 1'b0;
          rkey_valid = spur[g];
          rkey       = spur[g] ? 128'hdeadbeef_0badf00d_55aa55aa_12345678 : 128'd0;
        end else begin
          if (!pending) begin
            pending = 1'b1;
            lat = rand_lat[g] ? int'($urandom_range(0, 5)) : 0;
          end
          if (lat == 0) begin
            rkey_valid = 1'b1;
            rkey       = rk[g][rkey_idx[g]];
          end else begin
            rkey_valid = 1'b0;
            lat--;
          end
          prev_wait = !rkey_valid;
          prev_idx  = rkey_idx[g];
        end
      end
    end

    // Monitor: compares every accepted ciphertext against the scoreboard.
    initial begin : monitor
      forever begin
        @(negedge clk);
        if (rst_n && out_valid[g] && out_ready[g]) begin
          if (exp_q[g].size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output%0d: got %h, expected no output", g, state_out[g]);
          end else begin
            check($sformatf("ciphertext%0d", g), state_out[g], exp_q[g].pop_front());
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [127:0] row;
    row = sbox_rows[b[7:4]];
    return row[127-8*b[3:0] -: 8];
  endfunction

  task automatic expand(input int g, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int          nrr;
    nrr  = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nrr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rcon, 24'h000000};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nrr; r++) rk[g][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},  {127'd0, in_ready[0]},  128'd1);
    check({tag, "_out_valid"}, {127'd0, out_valid[0]}, 128'd0);
    check({tag, "_rkey_req"},  {127'd0, rkey_req[0]},  128'd0);
    check({tag, "_rkey_idx"},  {124'd0, rkey_idx[0]},  128'd0);
    check({tag, "_busy"},      {127'd0, busy[0]},      128'd0);
    check({tag, "_state"},     state_out[0],           128'd0);
  endtask

  task automatic send(input int g, input logic [127:0] pt, input logic [127:0] ct);
    exp_q[g].push_back(ct);
    state_in[g] = pt;
    in_valid[g] = 1'b1;
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(in_ready[g] && exp_q[g].size() == 0) && n < 400);
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL idle_timeout%0d: still busy after %0d cycles, expected idle", g, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_out(input int g);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid[g] && n < 400);
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL out_timeout%0d: out_valid low after %0d cycles, expected high", g, n);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [255:0] k1, k2, k3, kb;
    logic [127:0] ct [3];
    int           n;
    checks = 0; errors = 0; rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      in_valid[g] = 1'b0; out_ready[g] = 1'b1; state_in[g] = '0;
      rand_lat[g] = 1'b0; spur[g] = 1'b0;
    end
    k1 = {128'h000102030405060708090a0b0c0d0e0f, 128'd0};
    k2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'd0};
    k3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    kb = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0};
    ct[0] = CT1; ct[1] = CT2; ct[2] = CT3;
    expand(0, k1, 4); expand(1, k2, 6); expand(2, k3, 8);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // C.1/C.2/C.3 in parallel; C.1 request/index/valid timing traced per cycle.
    for (int g = 0; g < 3; g++) begin
      exp_q[g].push_back(ct[g]);
      state_in[g] = PT;
      in_valid[g] = 1'b1;
    end
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) in_valid[g] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k <= 11) begin
        check($sformatf("req_c%0d", k), {127'd0, rkey_req[0]}, 128'd1);
        check($sformatf("idx_c%0d", k), {124'd0, rkey_idx[0]}, 128'(k - 1));
      end
      check($sformatf("out_valid_c%0d", k), {127'd0, out_valid[0]}, (k == 12) ? 128'd1 : 128'd0);
    end
    for (int g = 0; g < 3; g++) wait_idle(g);

    // Random key latency, with a second known-answer vector in between.
    rand_lat[0] = 1'b1;
    send(0, PT, CT1); wait_idle(0);
    expand(0, kb, 4);
    send(0, PTB, CTB); wait_idle(0);
    expand(0, k1, 4);
    send(0, PT, CT1); wait_idle(0);
    rand_lat[0] = 1'b0;

    // Downstream stall for 7 cycles with in_valid pulses that must be ignored.
    out_ready[0] = 1'b0;
    send(0, PT, CT1);
    wait_out(0);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      in_valid[0] = i[0];
      state_in[0] = 128'hfeedface_cafebabe_01234567_89abcdef;
      @(negedge clk);
      check("hold_state",     state_out[0],           CT1);
      check("hold_in_ready",  {127'd0, in_ready[0]},  128'd0);
      check("hold_out_valid", {127'd0, out_valid[0]}, 128'd1);
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    wait_idle(0);
    check("hold_busy_after", {127'd0, busy[0]}, 128'd0);

    // Asynchronous reset while round 5 is requesting its key.
    send(0, PT, CT1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rkey_req[0] && rkey_idx[0] == 4'd5) && n < 100);
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL round5_timeout: index 5 not seen after %0d cycles, expected within 100", n);
    end
    #1 rst_n = 1'b0;
    #1;
    check_reset("midreset");
    void'(exp_q[0].pop_back());
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, PT, CT1); wait_idle(0);

    // Spurious key valid in IDLE and in DONE.
    spur[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("spur_idle_in_ready", {127'd0, in_ready[0]}, 128'd1);
      check("spur_idle_busy",     {127'd0, busy[0]},     128'd0);
      check("spur_idle_req",      {127'd0, rkey_req[0]}, 128'd0);
      check("spur_idle_state",    state_out[0],          CT1);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    send(0, PT, CT1);
    wait_out(0);
    repeat (3) begin
      @(negedge clk);
      check("spur_done_state",     state_out[0],           CT1);
      check("spur_done_out_valid", {127'd0, out_valid[0]}, 128'd1);
      check("spur_done_in_ready",  {127'd0, in_ready[0]},  128'd0);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    wait_idle(0);
    spur[0] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rijndael_round_ctrl.md
# rijndael_round_ctrl

Iterative Rijndael encryption controller: accepts one plaintext block over a valid/ready handshake and fetches one round key per round from an external key-schedule source. It steps a single combinational round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) NR times and presents the ciphertext on an output valid/ready handshake. It sits between the block-level cipher wrapper and the round datapath, which it sequences. It also gates MixColumns off for the final round.

## Interface
- NB, 4, block width in 32-bit columns (4, 6 or 8)
- NK, 4, key width in 32-bit words (4, 6 or 8)
- STATESIZE (localparam), 32*NB, state width in bits
- NR (localparam), max(NB,NK)+6, number of rounds

- clk_i  input  1  clock; single clock domain
- rst_ni  input  1  reset, asynchronous, active-low
- in_valid_i  input  1  plaintext valid
- in_ready_o  output  1  controller can accept plaintext
- state_i  input  STATESIZE  plaintext, column-major, byte 0 in MSBs
- rkey_req_o  output  1  round-key request
- rkey_idx_o  output  4  requested round-key index, 0..NR
- rkey_valid_i  input  1  round key present on rkey_i
- rkey_i  input  STATESIZE  round key for rkey_idx_o
- out_valid_o  output  1  ciphertext valid
- out_ready_i  input  1  downstream accepts ciphertext
- state_o  output  STATESIZE  ciphertext (state register)
- busy_o  output  1  high whenever FSM is not IDLE

## Operation
- FSM states: IDLE, INIT, ROUND, FINAL, DONE. Round counter rnd is 4 bits wide.
- IDLE: in_ready_o=1. When in_valid_i=1, load state_i into the state register, set rnd=0 and go to INIT.
- INIT: rkey_req_o=1, rkey_idx_o=0. When rkey_valid_i=1, set state ^= rkey_i and rnd=1. Then go to ROUND, or to FINAL if NR==1 (never the case for legal parameters).
- ROUND: rkey_req_o=1, rkey_idx_o=rnd. When rkey_valid_i=1, set state = AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rkey_i) and rnd++. Go to FINAL when the new rnd==NR.
- FINAL: same as ROUND, but MixColumns is bypassed (datapath input final_i=1). Then go to DONE.
- DONE: out_valid_o=1. When out_ready_i=1, go to IDLE.
- Key handshake: a key transfer occurs on a cycle where rkey_req_o and rkey_valid_i are both 1. rkey_req_o and rkey_idx_o are held stable until that transfer. rkey_valid_i while rkey_req_o=0 is ignored.
- in_valid_i outside IDLE is ignored. in_ready_o=0 in DONE, so there is no same-cycle turnaround.
- Output holding: state_o is held and out_valid_o stays 1 until out_ready_i=1.
- Reset mid-operation (asynchronous): all registers return to reset values and the FSM enters IDLE. An outstanding key request is dropped, and the key source must tolerate the abandoned request.
- Reset values: in_ready_o=1 (decoded from IDLE), out_valid_o=0, rkey_req_o=0, rkey_idx_o=0, busy_o=0, state_o=0.

## Timing
- All outputs are registered or decoded from FSM state only. There are no combinational paths from inputs to outputs.
- Zero-wait key source, acceptance at edge 0:
  - rkey_req_o is high on cycles 1..NR+1.
  - rkey_idx_o steps 0,1,…,NR, one index per cycle.
  - out_valid_o rises at cycle NR+2.
  - For AES-128 this is 12 cycles from acceptance to out_valid_o.
- Each cycle of rkey_valid_i=0 during a request adds exactly one cycle of latency.
- Each cycle of out_ready_i=0 in DONE adds one cycle before in_ready_o returns.
- Maximum throughput: one block per NR+3 cycles.

## Structure
- Shared package rijndael_pkg, containing:
  - function nr(nb,nk)
  - the FSM state enum type
  - the ShiftRows offset table per NB
- Sub-module rijndael_round (combinational), with:
  - parameter NB
  - ports state_i, rkey_i, final_i, state_o
  - internally it instantiates the existing MixColumns block; when final_i=1 MixColumns is bypassed
- The controller contains only the FSM, round counter, state register and handshakes.

## Test plan
- FIPS-197 C.1 (NB=4, NK=4), zero-wait key model:
  - stimulus: plaintext 00112233445566778899aabbccddeeff, key 000102…0f
  - response: state_o = 69c4e0d86a7b0430d8cdb78070b4c55a
  - out_valid_o at cycle 12; rkey_idx_o sequence 0..10
- FIPS-197 C.2 (NK=6) and C.3 (NK=8), same plaintext, keys 000102…17 and 000102…1f:
  - C.2 response: state_o = dda97ca4864cdfe06eaf70a0ec0d7191, NR=12
  - C.3 response: state_o = 8ea2b7ca516745bfeafc49904b496089, NR=14
- Random key-source latency of 0..5 cycles per request:
  - response: identical C.1 ciphertext
  - rkey_idx_o never changes while rkey_req_o=1 without rkey_valid_i
- out_ready_i held low for 7 cycles in DONE:
  - response: state_o stable and in_ready_o=0 throughout
  - in_valid_i pulses during this window are not accepted
- rst_ni asserted during round 5:
  - response: all outputs at reset values immediately
  - the next C.1 block encrypts correctly
- Spurious rkey_valid_i in IDLE and DONE:
  - response: no state change and no FSM transition
